// File: rtl/prod_accum_if.sv
`default_nettype none
// ============================================================================
// Module   : prod_accum_if
// Brief    : Product-stream, run-control and result signals for prod_accum.
// Revision : 1.0 - initial release
// ============================================================================
interface prod_accum_if #(
  parameter int ACC_W = 10
);
  logic [7:0]       p_in;
  logic             p_valid;
  logic             p_ready;
  logic             start;
  logic [3:0]       len;
  logic             busy;
  logic [ACC_W-1:0] acc_out;
  logic             acc_valid;
  logic             acc_ready;
  logic             ovf;

  modport master (
    output p_in, p_valid, start, len, acc_ready,
    input  p_ready, busy, acc_out, acc_valid, ovf
  );

  modport slave (
    input  p_in, p_valid, start, len, acc_ready,
    output p_ready, busy, acc_out, acc_valid, ovf
  );
endinterface
`default_nettype wire

// File: rtl/prod_accum.sv
`default_nettype none
// ============================================================================
// Module   : prod_accum
// Brief    : Accumulates a run of len products into an ACC_W-bit sum with a
//            sticky overflow flag. Define PROD_ACCUM_SATURATE_EN to clamp the
//            sum at 2^ACC_W-1 instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module prod_accum #(
  parameter int ACC_W = 10
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  prod_accum_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ACC_W-1:0] C_ACC_MAX = '1;

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_cnt;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic             w_beat;
  logic             w_last;
  logic [ACC_W:0]   w_sum;
  logic [ACC_W-1:0] w_acc_next;

  assign w_beat = (r_state == ACC) && bus.p_valid;
  // Counter starts at len (0 encodes 16), so the beat seen at 1 is the last.
  assign w_last = w_beat && (r_cnt == 4'd1);
  assign w_sum  = {1'b0, r_acc} + {{(ACC_W-7){1'b0}}, bus.p_in};

`ifdef PROD_ACCUM_SATURATE_EN
  assign w_acc_next = (w_sum[ACC_W] || r_ovf) ? C_ACC_MAX : w_sum[ACC_W-1:0];
`else
  assign w_acc_next = w_sum[ACC_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start)     w_next = ACC;
      ACC:     if (w_last)        w_next = DONE;
      DONE:    if (bus.acc_ready) w_next = IDLE;
      default:                    w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 4'd0;
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if ((r_state == IDLE) && bus.start) begin
      r_cnt <= bus.len;
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (w_beat) begin
      r_cnt <= r_cnt - 4'd1;
      r_acc <= w_acc_next;
      r_ovf <= r_ovf | w_sum[ACC_W];
    end
  end

  assign bus.p_ready   = (r_state == ACC);
  assign bus.busy      = (r_state != IDLE);
  assign bus.acc_valid = (r_state == DONE);
  assign bus.acc_out   = r_acc;
  assign bus.ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_prod_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_prod_accum
// Brief    : Scenario-driven bench for prod_accum with an expected-result queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prod_accum;

  localparam int ACC_W = 10;
  localparam int MAXV  = (1 << ACC_W) - 1;

  typedef struct {
    logic [ACC_W-1:0] acc;
    logic             ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  prod_accum_if #(.ACC_W(ACC_W)) bus ();

  prod_accum #(.ACC_W(ACC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int sum);
    exp_t e;
    e.ovf = (sum > MAXV);
`ifdef PROD_ACCUM_SATURATE_EN
    e.acc = (sum > MAXV) ? ACC_W'(MAXV) : ACC_W'(sum);
`else
    e.acc = ACC_W'(sum % (MAXV + 1));
`endif
    sb.push_back(e);
  endtask

  task automatic do_start(input logic [3:0] l);
    bus.start = 1'b1;
    bus.len   = l;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] p);
    bus.p_in    = p;
    bus.p_valid = 1'b1;
    tick();
    bus.p_valid = 1'b0;
  endtask

  task automatic release_result();
    bus.acc_ready = 1'b1;
    tick();
    bus.acc_ready = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    #1;
    n_checks++; if (bus.acc_out !== '0)   begin n_fail++; $display("FAIL reset_acc_out: got %0d want 0", bus.acc_out); end
    n_checks++; if (bus.ovf !== 1'b0)     begin n_fail++; $display("FAIL reset_ovf: got %b want 0", bus.ovf); end
    n_checks++; if (bus.acc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_acc_valid: got %b want 0", bus.acc_valid); end
    n_checks++; if (bus.p_ready !== 1'b0) begin n_fail++; $display("FAIL reset_p_ready: got %b want 0", bus.p_ready); end
    n_checks++; if (bus.busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    // start on the very first edge after deassertion
    do_start(4'd1);
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL first_edge_start: busy got %b want 1", bus.busy); end
    push_exp(3);
    send_beat(8'd3);
    e = sb.pop_front();
    n_checks++; if (bus.acc_out !== e.acc) begin n_fail++; $display("FAIL first_run_acc: got %0d want %0d", bus.acc_out, e.acc); end
    release_result();
  endtask

  task automatic test_basic();
    exp_t e;
    do_start(4'd3);
    n_checks++; if (bus.p_ready !== 1'b1) begin n_fail++; $display("FAIL basic_p_ready: got %b want 1", bus.p_ready); end
    push_exp(60);
    send_beat(8'd10);
    send_beat(8'd20);
    bus.p_in = 8'd30; bus.p_valid = 1'b1;
    n_checks++; if (bus.acc_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_early: got %b want 0", bus.acc_valid); end
    tick();
    bus.p_valid = 1'b0;
    n_checks++; if (bus.acc_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", bus.acc_valid); end
    n_checks++; if (bus.p_ready !== 1'b0) begin n_fail++; $display("FAIL basic_done_p_ready: got %b want 0", bus.p_ready); end
    e = sb.pop_front();
    n_checks++; if (bus.acc_out !== e.acc) begin n_fail++; $display("FAIL basic_acc: got %0d want %0d", bus.acc_out, e.acc); end
    n_checks++; if (bus.ovf !== e.ovf) begin n_fail++; $display("FAIL basic_ovf: got %b want %b", bus.ovf, e.ovf); end
    release_result();
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle: busy got %b want 0", bus.busy); end
    n_checks++; if (bus.acc_out !== e.acc) begin n_fail++; $display("FAIL basic_hold_idle: got %0d want %0d", bus.acc_out, e.acc); end
  endtask

  task automatic test_gapped();
    exp_t e;
    logic [3:0] vpat;
    logic [7:0] ppat [4];
    vpat = 4'b1001;
    ppat[0] = 8'd5; ppat[1] = 8'd99; ppat[2] = 8'd77; ppat[3] = 8'd7;
    do_start(4'd2);
    push_exp(12);
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL gapped_busy[%0d]: got %b want 1", i, bus.busy); end
      bus.p_in = ppat[i]; bus.p_valid = vpat[3-i];
      tick();
    end
    bus.p_valid = 1'b0;
    n_checks++; if (bus.acc_valid !== 1'b1) begin n_fail++; $display("FAIL gapped_valid: got %b want 1", bus.acc_valid); end
    e = sb.pop_front();
    n_checks++; if (bus.acc_out !== e.acc) begin n_fail++; $display("FAIL gapped_acc: got %0d want %0d", bus.acc_out, e.acc); end
    release_result();
  endtask

  task automatic test_overflow();
    exp_t e;
    do_start(4'd0);
    push_exp(16 * 225);
    for (int i = 0; i < 15; i++) send_beat(8'd225);
    n_checks++; if (bus.acc_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_len16_early: got %b want 0", bus.acc_valid); end
    send_beat(8'd225);
    n_checks++; if (bus.acc_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_len16_valid: got %b want 1", bus.acc_valid); end
    e = sb.pop_front();
    n_checks++; if (bus.acc_out !== e.acc) begin n_fail++; $display("FAIL ovf_acc: got %0d want %0d", bus.acc_out, e.acc); end
    n_checks++; if (bus.ovf !== e.ovf) begin n_fail++; $display("FAIL ovf_flag: got %b want %b", bus.ovf, e.ovf); end
    release_result();
    n_checks++; if (bus.ovf !== e.ovf) begin n_fail++; $display("FAIL ovf_hold_idle: got %b want %b", bus.ovf, e.ovf); end
  endtask

  task automatic test_done_hold();
    exp_t e;
    do_start(4'd1);
    push_exp(77);
    send_beat(8'd77);
    e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      bus.start = 1'b1; bus.len = 4'd5; bus.acc_ready = 1'b0;
      bus.p_valid = 1'b1; bus.p_in = 8'd200;
      tick();
      n_checks++; if (bus.acc_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid[%0d]: got %b want 1", i, bus.acc_valid); end
      n_checks++; if (bus.acc_out !== e.acc) begin n_fail++; $display("FAIL hold_acc[%0d]: got %0d want %0d", i, bus.acc_out, e.acc); end
    end
    // start coinciding with acc_ready must not launch a run
    bus.p_valid = 1'b0;
    bus.acc_ready = 1'b1;
    tick();
    bus.start = 1'b0; bus.acc_ready = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL hold_to_idle: busy got %b want 0", bus.busy); end
    n_checks++; if (bus.acc_out !== e.acc) begin n_fail++; $display("FAIL hold_idle_acc: got %0d want %0d", bus.acc_out, e.acc); end
    do_start(4'd1);
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL hold_restart: busy got %b want 1", bus.busy); end
    push_exp(4);
    send_beat(8'd4);
    e = sb.pop_front();
    n_checks++; if (bus.acc_out !== e.acc) begin n_fail++; $display("FAIL hold_restart_acc: got %0d want %0d", bus.acc_out, e.acc); end
    release_result();
  endtask

  task automatic test_reset_midrun();
    exp_t e;
    do_start(4'd4);
    send_beat(8'd50);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.acc_out !== '0) begin n_fail++; $display("FAIL midrst_acc: got %0d want 0", bus.acc_out); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.p_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_p_ready: got %b want 0", bus.p_ready); end
    n_checks++; if (bus.acc_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", bus.acc_valid); end
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    n_checks++; if (bus.acc_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_no_partial: got %b want 0", bus.acc_valid); end
    do_start(4'd1);
    push_exp(9);
    send_beat(8'd9);
    n_checks++; if (bus.acc_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_rerun_valid: got %b want 1", bus.acc_valid); end
    e = sb.pop_front();
    n_checks++; if (bus.acc_out !== e.acc) begin n_fail++; $display("FAIL midrst_rerun_acc: got %0d want %0d", bus.acc_out, e.acc); end
    release_result();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   l, sent, sum, budget;
    logic [7:0] p;
    for (int r = 0; r < 6; r++) begin
      l = $urandom_range(6, 1);
      do_start(4'(l));
      sent = 0; sum = 0; budget = 0;
      while (sent < l && budget < 200) begin
        p = 8'($urandom_range(225, 0));
        bus.p_in = p;
        bus.p_valid = ($urandom_range(1, 0) == 1);
        if (bus.p_valid && bus.p_ready) begin
          sent++; sum += int'(p);
        end
        tick();
        budget++;
      end
      bus.p_valid = 1'b0;
      push_exp(sum);
      n_checks++; if (sent != l) begin n_fail++; $display("FAIL b2b_timeout[%0d]: sent %0d want %0d", r, sent, l); end
      n_checks++; if (bus.acc_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b want 1", r, bus.acc_valid); end
      e = sb.pop_front();
      n_checks++; if (bus.acc_out !== e.acc) begin n_fail++; $display("FAIL b2b_acc[%0d]: got %0d want %0d", r, bus.acc_out, e.acc); end
      n_checks++; if (bus.ovf !== e.ovf) begin n_fail++; $display("FAIL b2b_ovf[%0d]: got %b want %b", r, bus.ovf, e.ovf); end
      release_result();
    end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover: got %0d want 0", sb.size()); end
  endtask

  initial begin
    bus.p_in = '0; bus.p_valid = 1'b0; bus.start = 1'b0;
    bus.len = '0; bus.acc_ready = 1'b0;
    test_reset();
    test_basic();
    test_gapped();
    test_overflow();
    test_done_hold();
    test_reset_midrun();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prod_accum.md
PROD_ACCUM -- requirements
Module: prod_accum

Interface
REQ-001 Parameter ACC_W, default 10: accumulator width in bits, legal range 8..16.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 p_in  input  8  unsigned product from the upstream 4x4 vedic multiplier (0..225).
REQ-005 p_valid  input  1  p_in carries a valid product this cycle.
REQ-006 p_ready  output  1  block accepts a product this cycle.
REQ-007 start  input  1  single-cycle pulse that begins a new accumulation run.
REQ-008 len  input  4  products per run, sampled at start; 0 means 16.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 acc_out  output  ACC_W  accumulated sum.
REQ-011 acc_valid  output  1  acc_out holds a finished result.
REQ-012 acc_ready  input  1  downstream consumes the result.
REQ-013 ovf  output  1  sticky flag: the run exceeded 2^ACC_W-1.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, ACC and DONE.
REQ-015 IDLE: start=1 SHALL latch len into the remaining-beat counter, clear acc_out and ovf, and move to ACC on the next edge.
REQ-016 ACC: p_ready SHALL be 1; a beat is accepted on any edge where p_valid and p_ready are both 1.
REQ-017 Each accepted beat SHALL add zero-extended p_in to the accumulator and decrement the counter on the same edge.
REQ-018 When the last beat of the run is accepted, the FSM SHALL enter DONE on that edge, so acc_valid rises in the following cycle.
REQ-019 In ACC, cycles with p_valid=0 SHALL leave the accumulator and counter unchanged, and the run SHALL have no timeout.
REQ-020 DONE: acc_valid SHALL be 1, p_ready SHALL be 0, and acc_out and ovf SHALL stay stable until acc_ready=1.
REQ-021 DONE with acc_ready=1 SHALL return the FSM to IDLE on the next edge; acc_out and ovf keep their values until the next start.
REQ-022 start SHALL be ignored in ACC and DONE, including when it coincides with acc_ready in DONE.
REQ-023 p_ready SHALL be 0 in IDLE and DONE, and p_valid in those states SHALL be ignored.
REQ-024 The maximum run sum is 16 x 225 = 3600; any carry out of bit ACC_W-1 SHALL set ovf.

Reset
REQ-025 rst_n=0 SHALL immediately force: state IDLE, acc_out=0, ovf=0, acc_valid=0, p_ready=0, busy=0, counter=0.
REQ-026 Reset asserted mid-run SHALL abort the run, and no partial result SHALL be presented afterwards.
REQ-027 After rst_n deasserts, the first edge SHALL be able to accept start.

Configuration
REQ-028 Macro PROD_ACCUM_SATURATE_EN: when defined, an overflowing add SHALL clamp acc_out to 2^ACC_W-1, and later beats SHALL keep it clamped.
REQ-029 When PROD_ACCUM_SATURATE_EN is not defined, the accumulator SHALL wrap modulo 2^ACC_W.
REQ-030 ovf SHALL behave the same whether or not PROD_ACCUM_SATURATE_EN is defined.

Verification
REQ-031 start with len=3; products 10, 20, 30, each with p_valid=1 on consecutive cycles -> acc_valid rises 1 cycle after the third beat, acc_out=60, ovf=0.
REQ-032 len=2; p_valid gapped (1, 0, 0, 1) with p_in 5 then 7 -> only 2 beats accepted, acc_out=12, busy=1 throughout the run.
REQ-033 ACC_W=10, len=0 (16 beats), each p_in=225 -> ovf=1; acc_out=1023 with the macro defined, 3600 mod 1024 = 528 without it.
REQ-034 In DONE, hold acc_ready=0 for 5 cycles while pulsing start -> acc_out stable, FSM stays in DONE; acc_ready=1 -> IDLE next cycle; a new start is then accepted.
REQ-035 rst_n pulsed low after 1 of 4 beats (p_in=50) -> all outputs 0 immediately; a following run with len=1 and p_in=9 -> acc_out=9.
